// File: rtl/pipelined_skip_carry_adder.sv
// pipelined_skip_carry_adder: N-bit carry-skip add/sub split into S register stages of P skip blocks each,
// all stages advancing together under a single valid/ready enable.
module pipelined_skip_carry_adder #(
    parameter int N = 32,
    parameter int B = 4,
    parameter int P = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   in1,
    input  logic [N-1:0]   in2,
    input  logic           cin,
    input  logic           sub,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   s,
    output logic           cout,
    output logic           OF,
    output logic [N/B-1:0] skip_mask
);
    localparam int NB = N / B;
    localparam int S = (NB + P - 1) / P;

    logic          v_r [S];
    logic          c_r [S];
    logic [N-1:0]  a_r [S];
    logic [N-1:0]  b_r [S];
    logic [N-1:0]  s_r [S];
    logic [NB-1:0] m_r [S];
    logic          v_n [S];
    logic          c_n [S];
    logic [N-1:0]  a_n [S];
    logic [N-1:0]  b_n [S];
    logic [N-1:0]  s_n [S];
    logic [NB-1:0] m_n [S];
    logic          adv;

    assign adv = !v_r[S-1] || out_ready;
    assign in_ready = adv;

    // Stage j finishes blocks j*P.. using the carry left by stage j-1; stage 0 works on the live operands.
    always_comb begin
        logic [N-1:0]  a, b, sm;
        logic [NB-1:0] m;
        logic          c, rc, x, p;
        int            pj;
        a = '0;
        b = '0;
        sm = '0;
        m = '0;
        c = 1'b0;
        rc = 1'b0;
        x = 1'b0;
        p = 1'b0;
        pj = 0;
        for (int j = 0; j < S; j++) begin
            pj = j == 0 ? 0 : j - 1;
            v_n[j] = j == 0 ? in_valid : v_r[pj];
            a = j == 0 ? in1 : a_r[pj];
            b = j == 0 ? in2 ^ {N{sub}} : b_r[pj];
            c = j == 0 ? sub | cin : c_r[pj];
            sm = j == 0 ? '0 : s_r[pj];
            m = j == 0 ? '0 : m_r[pj];
            for (int k = j * P; k < NB && k < j * P + P; k++) begin
                rc = c;
                p = 1'b1;
                for (int i = k * B; i < k * B + B; i++) begin
                    x = a[i] ^ b[i];
                    sm[i] = x ^ rc;
                    rc = (a[i] & b[i]) | (x & rc);
                    p = p & x;
                end
                m[k] = p;
                c = p ? c : rc;
            end
            a_n[j] = a;
            b_n[j] = b;
            s_n[j] = sm;
            c_n[j] = c;
            m_n[j] = m;
        end
    end

    always_ff @(posedge clk) begin
        for (int j = 0; j < S; j++) begin
            if (!rst_n) begin
                v_r[j] <= 1'b0;
                c_r[j] <= 1'b0;
                a_r[j] <= '0;
                b_r[j] <= '0;
                s_r[j] <= '0;
                m_r[j] <= '0;
            end else if (adv) begin
                v_r[j] <= v_n[j];
                c_r[j] <= c_n[j];
                a_r[j] <= a_n[j];
                b_r[j] <= b_n[j];
                s_r[j] <= s_n[j];
                m_r[j] <= m_n[j];
            end
        end
    end

    assign out_valid = v_r[S-1];
    assign s = s_r[S-1];
    assign cout = c_r[S-1];
    assign skip_mask = m_r[S-1];
    assign OF = (a_r[S-1][N-1] == b_r[S-1][N-1]) && (s_r[S-1][N-1] != a_r[S-1][N-1]);
endmodule

// File: tb/tb_pipelined_skip_carry_adder.sv
// tb_pipelined_skip_carry_adder: table vectors, stall/reset sequences and a random sweep over three
// configurations, each checked against an arithmetic reference model with a stall-aware latency check.
module tb_pipelined_skip_carry_adder;
    typedef struct {
        logic [31:0] s;
        logic        co;
        logic        of;
        logic [7:0]  m;
        int          cyc;
        int          st;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        co;
        logic        of;
        logic [7:0]  m;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid [3];
    logic        out_ready [3];
    logic        cin [3];
    logic        sub [3];
    logic        in_ready [3];
    logic        out_valid [3];
    logic        cout [3];
    logic        of [3];
    logic [31:0] in1 [3];
    logic [31:0] in2 [3];
    logic [31:0] s [3];
    logic [7:0]  mask [3];
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    int          pushed = 0;
    int          popped = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain wide arithmetic; a block skips when every bit of A^Be in it is 1.
    function automatic exp_t model(input int w, input int bw, input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input logic sb);
        exp_t e;
        logic [63:0] msk, am, bm, sum, blk;
        msk = (64'd1 << w) - 64'd1;
        am = {32'd0, a} & msk;
        bm = (sb ? ~{32'd0, b} : {32'd0, b}) & msk;
        sum = am + bm + (sb ? 64'd1 : {63'd0, ci});
        e.s = 32'(sum & msk);
        e.co = sum[w];
        e.of = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
        blk = (64'd1 << bw) - 64'd1;
        e.m = '0;
        for (int k = 0; k < w / bw; k++) e.m[k] = (((am ^ bm) >> (k * bw)) & blk) == blk;
        e.cyc = 0;
        e.st = 0;
        return e;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int W = g == 0 ? 32 : g == 1 ? 16 : 24;
        localparam int BW = g == 2 ? 8 : 4;
        localparam int PP = g == 1 ? 1 : 2;
        localparam int SS = (W / BW + PP - 1) / PP;
        logic [W-1:0]    so;
        logic [W/BW-1:0] mo;
        exp_t            q [$];
        exp_t            e;
        int              st = 0;
        logic            held = 1'b0;
        logic [31:0]     hs;
        logic            hc, ho;
        logic [7:0]      hm;

        pipelined_skip_carry_adder #(.N(W), .B(BW), .P(PP)) dut (
            .clk(clk), .rst_n(rst_n), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
            .in1(in1[g][W-1:0]), .in2(in2[g][W-1:0]), .cin(cin[g]), .sub(sub[g]),
            .out_valid(out_valid[g]), .out_ready(out_ready[g]), .s(so), .cout(cout[g]),
            .OF(of[g]), .skip_mask(mo)
        );
        assign s[g] = 32'(so);
        assign mask[g] = 8'(mo);

        // Every stalled cycle delays everything in flight by exactly one cycle.
        always @(negedge clk) begin
            if (!rst_n) begin
                pushed -= q.size();
                q.delete();
                held = 1'b0;
            end else begin
                chk($sformatf("u%0d.in_ready", g), in_ready[g], !out_valid[g] || out_ready[g]);
                if (held) begin
                    chk($sformatf("u%0d.hold_valid", g), out_valid[g], 1);
                    chk($sformatf("u%0d.hold_s", g), s[g], hs);
                    chk($sformatf("u%0d.hold_cout", g), cout[g], hc);
                    chk($sformatf("u%0d.hold_of", g), of[g], ho);
                    chk($sformatf("u%0d.hold_mask", g), mask[g], hm);
                end
                if (out_valid[g] && out_ready[g]) begin
                    if (q.size() == 0) chk($sformatf("u%0d.spurious_out", g), 1, 0);
                    else begin
                        e = q.pop_front();
                        popped++;
                        chk($sformatf("u%0d.s", g), s[g], e.s);
                        chk($sformatf("u%0d.cout", g), cout[g], e.co);
                        chk($sformatf("u%0d.of", g), of[g], e.of);
                        chk($sformatf("u%0d.mask", g), mask[g], e.m);
                        chk($sformatf("u%0d.latency", g), cyc - e.cyc, SS + st - e.st);
                    end
                end
                if (in_valid[g] && in_ready[g]) begin
                    e = model(W, BW, in1[g], in2[g], cin[g], sub[g]);
                    e.cyc = cyc;
                    e.st = st;
                    q.push_back(e);
                    pushed++;
                end
                held = out_valid[g] && !out_ready[g];
                st += held;
                hs = s[g];
                hc = cout[g];
                ho = of[g];
                hm = mask[g];
            end
        end
    end

    initial begin
        vec_t tv [7];
        int   n;
        logic acc;
        tv[0] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'hFF};
        tv[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 8'h7E};
        tv[2] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 8'hFE};
        tv[3] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 8'h7E};
        tv[4] = '{32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b1, 32'h0001FFFF, 1'b0, 1'b0, 8'h00};
        tv[5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 8'h00};
        tv[6] = '{32'h0000FFFF, 32'hFFFF0000, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 8'hFF};
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0;
            out_ready[g] = 1'b1;
            cin[g] = 1'b0;
            sub[g] = 1'b0;
            in1[g] = '0;
            in2[g] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst.out_valid", out_valid[0], 0);
        chk("rst.s", s[0], 0);
        chk("rst.cout", cout[0], 0);
        chk("rst.of", of[0], 0);
        chk("rst.mask", mask[0], 0);
        chk("rst.in_ready", in_ready[0], 1);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            in_valid[0] = 1'b1;
            in1[0] = tv[i].a;
            in2[0] = tv[i].b;
            cin[0] = tv[i].ci;
            sub[0] = tv[i].sb;
            @(posedge clk);
            #1;
            in_valid[0] = 1'b0;
            n = 1;
            while (!out_valid[0] && n < 20) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk($sformatf("tv%0d.latency", i), n, 4);
            chk($sformatf("tv%0d.s", i), s[0], tv[i].s);
            chk($sformatf("tv%0d.cout", i), cout[0], tv[i].co);
            chk($sformatf("tv%0d.of", i), of[0], tv[i].of);
            chk($sformatf("tv%0d.mask", i), mask[0], tv[i].m);
            @(posedge clk);
            #1;
        end

        n = 0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            in_valid[0] = 1'b1;
            in1[0] = $urandom;
            in2[0] = $urandom;
            cin[0] = 1'($urandom);
            sub[0] = 1'($urandom);
            out_ready[0] = !(c >= 5 && c < 8);
            @(negedge clk);
            acc = in_ready[0];
            if (c >= 5 && c < 8) chk("stall.in_ready", in_ready[0], 0);
            @(posedge clk);
            #1;
            n += int'(acc);
        end
        chk("stream.sent", n, 10);
        in_valid[0] = 1'b0;
        out_ready[0] = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        for (int c = 0; c < 3; c++) begin
            in_valid[0] = 1'b1;
            in1[0] = $urandom;
            in2[0] = $urandom;
            cin[0] = 1'($urandom);
            sub[0] = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst.out_valid", out_valid[0], 0);
        chk("midrst.s", s[0], 0);
        chk("midrst.cout", cout[0], 0);
        chk("midrst.of", of[0], 0);
        chk("midrst.mask", mask[0], 0);
        chk("midrst.in_ready", in_ready[0], 1);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;

        for (int c = 0; c < 1900; c++) begin
            for (int g = 0; g < 3; g++) begin
                in_valid[g] = c < 1100 ? 1'b1 : $urandom_range(0, 3) != 0;
                out_ready[g] = c < 1100 ? 1'b1 : $urandom_range(0, 3) != 0;
                in1[g] = $urandom;
                in2[g] = $urandom;
                cin[g] = 1'($urandom);
                sub[g] = 1'($urandom);
            end
            @(posedge clk);
            #1;
        end
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0;
            out_ready[g] = 1'b1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk("drained", popped, pushed);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
